// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the Hack program-counter sequencer.
// State encoding is fixed so that waveform viewers and debug probes agree.
package pc_seq_pkg;

    localparam int          PC_WIDTH    = 16;
    localparam logic [15:0] RETIRED_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    // Retired-instruction counter step: sticks at the top instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == RETIRED_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pc_sequencer_inc16.sv
// 16-bit wrapping incrementer shared with the rest of the Hack datapath.
// Overflow from 16'hFFFF silently wraps to 16'h0000.
module inc16
    import pc_seq_pkg::*;
(
    input  logic [PC_WIDTH-1:0] i_a,
    output logic [PC_WIDTH-1:0] o_y
);

    assign o_y = i_a + {{(PC_WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: fetches over a req/ack handshake, advances or
// redirects the PC on instruction completion, and halts on a self-jump.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                WIDTH      = 16,
    parameter logic [WIDTH-1:0]  RESET_ADDR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    output logic             rom_req,
    output logic [WIDTH-1:0] rom_addr,
    input  logic             rom_ack,
    output logic             instr_valid,
    input  logic             exec_done,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_addr,
    output logic [WIDTH-1:0] pc,
    output logic             halted,
    output logic [15:0]      retired
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_pc_inc;
    logic [15:0]      r_retired;
    logic [15:0]      w_retired_next;
    logic             r_instr_valid;
    logic             w_instr_valid_next;
    logic             w_self_jump;

    inc16 u_inc (
        .i_a (r_pc),
        .o_y (w_pc_inc)
    );

    // "@END; 0;JMP" idiom: a taken jump back onto the instruction itself.
    assign w_self_jump = jump && (jump_addr == r_pc);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc          <= RESET_ADDR;
            r_retired     <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_retired     <= w_retired_next;
            r_instr_valid <= w_instr_valid_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_retired_next     = r_retired;
        w_instr_valid_next = 1'b0;

        case (r_state)
            IDLE: begin
                if (run) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                // Registering the ack makes instr_valid mark the first EXEC cycle.
                if (rom_ack) begin
                    w_state_next       = EXEC;
                    w_instr_valid_next = 1'b1;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    if (w_self_jump) begin
                        w_state_next = HALT;
                    end else begin
                        w_pc_next      = jump ? jump_addr : w_pc_inc;
                        w_retired_next = sat_inc16(r_retired);
                        w_state_next   = run ? FETCH : IDLE;
                    end
                end
            end
            HALT: begin
                w_state_next = HALT;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign rom_req     = (r_state == FETCH);
    assign rom_addr    = r_pc;
    assign pc          = r_pc;
    assign halted      = (r_state == HALT);
    assign retired     = r_retired;
    assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table, directed corner cases,
// and a randomized run checked against an instruction-level model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        rom_req;
    logic [15:0] rom_addr;
    logic        rom_ack;
    logic        instr_valid;
    logic        exec_done;
    logic        jump;
    logic [15:0] jump_addr;
    logic [15:0] pc;
    logic        halted;
    logic [15:0] retired;

    int n_total = 0;
    int n_pass  = 0;

    pc_sequencer #(.WIDTH(16), .RESET_ADDR(16'h0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .rom_ack     (rom_ack),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .pc          (pc),
        .halted      (halted),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        run;
        logic        ack;
        logic        done;
        logic        jmp;
        logic [15:0] jaddr;
        logic        req;
        logic        iv;
        logic [15:0] pc;
        logic        halt;
        logic [15:0] ret;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic r, input logic a, input logic d,
                                    input logic j, input logic [15:0] ja,
                                    input logic req, input logic iv,
                                    input logic [15:0] p, input logic h,
                                    input logic [15:0] ret);
        vec_t v;
        v.run = r; v.ack = a; v.done = d; v.jmp = j; v.jaddr = ja;
        v.req = req; v.iv = iv; v.pc = p; v.halt = h; v.ret = ret;
        vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic quiet_inputs();
        run = 1'b0; rom_ack = 1'b0; exec_done = 1'b0; jump = 1'b0; jump_addr = 16'h0000;
    endtask

    task automatic do_reset();
        quiet_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic start_run();
        run = 1'b1;
        tick();
    endtask

    // Assumes the DUT is in FETCH; withholds ack for wait_cycles, then acks.
    task automatic fetch(input int wait_cycles, input logic [15:0] exp_addr);
        for (int w = 0; w < wait_cycles; w++) begin
            rom_ack = 1'b0;
            tick();
            check1("stall_req", rom_req, 1'b1);
            check16("stall_addr", rom_addr, exp_addr);
        end
        rom_ack = 1'b1;
        tick();
        rom_ack = 1'b0;
        check1("fetch_iv", instr_valid, 1'b1);
    endtask

    task automatic complete(input logic j, input logic [15:0] a, input logic r);
        run = r; exec_done = 1'b1; jump = j; jump_addr = a; rom_ack = 1'b0;
        tick();
        exec_done = 1'b0; jump = 1'b0;
    endtask

    logic [15:0] exp_pc;
    logic [15:0] exp_ret;
    logic        r_bit;
    logic        j_bit;
    logic [15:0] a_val;

    initial begin
        reset = 1'b0;
        quiet_inputs();

        // Reset state
        do_reset();
        check1("rst_req", rom_req, 1'b0);
        check1("rst_iv", instr_valid, 1'b0);
        check1("rst_halted", halted, 1'b0);
        check16("rst_pc", pc, 16'h0000);
        check16("rst_retired", retired, 16'h0000);

        // Sequential run: ack one cycle after req, done on instr_valid
        add_vec(1,0,0,0,0, 1,0,16'd0,0,16'd0);
        add_vec(1,0,0,0,0, 1,0,16'd0,0,16'd0);
        add_vec(1,1,0,0,0, 0,1,16'd0,0,16'd0);
        add_vec(1,0,1,0,0, 1,0,16'd1,0,16'd1);
        add_vec(1,0,0,0,0, 1,0,16'd1,0,16'd1);
        add_vec(1,1,0,0,0, 0,1,16'd1,0,16'd1);
        add_vec(1,0,1,0,0, 1,0,16'd2,0,16'd2);
        add_vec(1,0,0,0,0, 1,0,16'd2,0,16'd2);
        add_vec(1,1,0,0,0, 0,1,16'd2,0,16'd2);
        add_vec(1,0,1,0,0, 1,0,16'd3,0,16'd3);
        add_vec(1,0,0,0,0, 1,0,16'd3,0,16'd3);
        add_vec(1,1,0,0,0, 0,1,16'd3,0,16'd3);
        add_vec(1,0,1,0,0, 1,0,16'd4,0,16'd4);
        for (int i = 0; i < vecs.size(); i++) begin
            run = vecs[i].run; rom_ack = vecs[i].ack; exec_done = vecs[i].done;
            jump = vecs[i].jmp; jump_addr = vecs[i].jaddr;
            tick();
            check1($sformatf("tbl%0d_req", i), rom_req, vecs[i].req);
            check1($sformatf("tbl%0d_iv", i), instr_valid, vecs[i].iv);
            check16($sformatf("tbl%0d_addr", i), rom_addr, vecs[i].pc);
            check1($sformatf("tbl%0d_halted", i), halted, vecs[i].halt);
            check16($sformatf("tbl%0d_retired", i), retired, vecs[i].ret);
        end

        // Jump and wrap
        do_reset();
        start_run();
        fetch(0, 16'h0000);
        complete(1'b1, 16'hFFFE, 1'b1);
        check16("wrap_pc0", pc, 16'hFFFE);
        fetch(0, 16'hFFFE);
        complete(1'b0, 16'h0000, 1'b1);
        check16("wrap_pc1", pc, 16'hFFFF);
        fetch(0, 16'hFFFF);
        complete(1'b0, 16'h0000, 1'b1);
        check16("wrap_pc2", pc, 16'h0000);
        check1("wrap_req", rom_req, 1'b1);
        fetch(0, 16'h0000);
        complete(1'b1, 16'h0005, 1'b1);
        check16("jmp_pc5", pc, 16'h0005);
        fetch(1, 16'h0005);
        complete(1'b1, 16'h0010, 1'b1);
        check16("jmp_addr10", rom_addr, 16'h0010);
        check1("jmp_req10", rom_req, 1'b1);

        // Halt on self-jump; six instructions retired so far in this segment
        fetch(0, 16'h0010);
        complete(1'b1, 16'h0020, 1'b1);
        fetch(0, 16'h0020);
        complete(1'b1, 16'h0020, 1'b1);
        check1("halt_flag", halted, 1'b1);
        check1("halt_req", rom_req, 1'b0);
        check16("halt_retired", retired, 16'd6);
        check16("halt_pc", pc, 16'h0020);
        for (int k = 0; k < 4; k++) begin
            run = 1'b1; rom_ack = 1'b1; exec_done = 1'b1; jump = 1'(k); jump_addr = 16'h0100;
            tick();
            check1("halt_hold_flag", halted, 1'b1);
            check1("halt_hold_req", rom_req, 1'b0);
            check1("halt_hold_iv", instr_valid, 1'b0);
            check16("halt_hold_pc", pc, 16'h0020);
            check16("halt_hold_ret", retired, 16'd6);
        end
        do_reset();
        check1("halt_reset_flag", halted, 1'b0);
        check16("halt_reset_pc", pc, 16'h0000);

        // Pause during EXEC, then resume; also a 5-cycle ROM stall
        start_run();
        fetch(5, 16'h0000);
        complete(1'b0, 16'h0000, 1'b0);
        check1("pause_req", rom_req, 1'b0);
        check16("pause_pc", pc, 16'h0001);
        check16("pause_ret", retired, 16'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check1("pause_hold_req", rom_req, 1'b0);
            check16("pause_hold_pc", pc, 16'h0001);
        end
        run = 1'b1;
        tick();
        check1("resume_req", rom_req, 1'b1);
        check16("resume_addr", rom_addr, 16'h0001);
        fetch(0, 16'h0001);
        complete(1'b0, 16'h0000, 1'b1);

        // Reset while fetching at 0x0042, then stray handshakes in IDLE
        complete(1'b0, 16'h0000, 1'b1);
        fetch(0, 16'h0002);
        complete(1'b1, 16'h0042, 1'b1);
        check16("mid_pc42", pc, 16'h0042);
        check1("mid_req42", rom_req, 1'b1);
        reset = 1'b1; run = 1'b1; rom_ack = 1'b1;
        tick();
        reset = 1'b0;
        quiet_inputs();
        check1("mid_rst_req", rom_req, 1'b0);
        check16("mid_rst_pc", pc, 16'h0000);
        check16("mid_rst_ret", retired, 16'h0000);
        check1("mid_rst_iv", instr_valid, 1'b0);
        for (int k = 0; k < 3; k++) begin
            run = 1'b0; rom_ack = 1'b1; exec_done = 1'b1; jump = 1'b1; jump_addr = 16'h0000;
            tick();
            check1("stray_req", rom_req, 1'b0);
            check1("stray_iv", instr_valid, 1'b0);
            check1("stray_halted", halted, 1'b0);
            check16("stray_pc", pc, 16'h0000);
            check16("stray_ret", retired, 16'h0000);
        end

        // Randomized instruction stream against the instruction-level model
        do_reset();
        exp_pc = 16'h0000;
        exp_ret = 16'h0000;
        start_run();
        check1("rnd_start_req", rom_req, 1'b1);
        for (int i = 0; i < 300; i++) begin
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
                rom_ack = 1'b0; exec_done = 1'($urandom); jump = 1'($urandom);
                jump_addr = 16'($urandom); run = 1'($urandom);
                tick();
                check1("rnd_fetch_req", rom_req, 1'b1);
                check16("rnd_fetch_addr", rom_addr, exp_pc);
                check1("rnd_fetch_iv", instr_valid, 1'b0);
            end
            exec_done = 1'b0; rom_ack = 1'b1;
            tick();
            rom_ack = 1'b0;
            check1("rnd_iv", instr_valid, 1'b1);
            check1("rnd_exec_req", rom_req, 1'b0);
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
                exec_done = 1'b0; rom_ack = 1'($urandom); jump = 1'($urandom);
                jump_addr = 16'($urandom); run = 1'($urandom);
                tick();
                check1("rnd_wait_iv", instr_valid, 1'b0);
                check1("rnd_wait_req", rom_req, 1'b0);
                check16("rnd_wait_pc", pc, exp_pc);
            end
            j_bit = ($urandom_range(0, 3) == 0);
            a_val = 16'($urandom);
            if (a_val == exp_pc) a_val = a_val ^ 16'h0001;
            r_bit = ($urandom_range(0, 4) != 0);
            complete(j_bit, a_val, r_bit);
            exp_pc  = j_bit ? a_val : 16'((32'(exp_pc) + 1) % 65536);
            exp_ret = (exp_ret == 16'hFFFF) ? exp_ret : exp_ret + 16'd1;
            check16("rnd_pc", pc, exp_pc);
            check16("rnd_ret", retired, exp_ret);
            check1("rnd_next_req", rom_req, r_bit);
            check1("rnd_halted", halted, 1'b0);
            if (!r_bit) begin
                for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
                    run = 1'b0; rom_ack = 1'($urandom); exec_done = 1'($urandom);
                    tick();
                    check1("rnd_idle_req", rom_req, 1'b0);
                    check16("rnd_idle_pc", pc, exp_pc);
                end
                rom_ack = 1'b0; exec_done = 1'b0; run = 1'b1;
                tick();
                check1("rnd_resume_req", rom_req, 1'b1);
            end
        end
        // End the random stream with a self-jump
        fetch(0, exp_pc);
        complete(1'b1, exp_pc, 1'b1);
        check1("rnd_final_halt", halted, 1'b1);
        check16("rnd_final_ret", retired, exp_ret);
        check16("rnd_final_pc", pc, exp_pc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
